pcra_unit: RTL
==============

Name: pcra_unit

Overview:
- Holds the two 16-bit program-counter/return-address registers, PCRA0 and PCRA1, and the flip bit that selects which one is the active PC.
- Sits directly upstream of the control pipeline:
  - drives the fetch address whose data arrives at control bus_in;
  - consumes control_inc_pcra0/1 from stage 0;
  - consumes the pcraflip command (control_stage2[14]).
- Jumps and calls work by byte-loading the inactive register (RA) from the data bus, then flipping.

Parameters:
- WIDTH, 8, data bus width
- ADDR_WIDTH, 16, register/address width; must equal 2*WIDTH
- RESET_VECTOR, 16'h0000, value loaded into PCRA0 on reset

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- inc_pcra0  input  1  increment PCRA0 this cycle
- inc_pcra1  input  1  increment PCRA1 this cycle
- flip_req  input  1  toggle flip bit (swap PC/RA roles)
- bus_in  input  WIDTH  data bus byte for loads
- load_ra_lo  input  1  write bus_in into RA[7:0]
- load_ra_hi  input  1  write bus_in into RA[15:8]
- read_sel  input  2  byte select for bus_out: 0=PC lo, 1=PC hi, 2=RA lo, 3=RA hi
- addr_sel  input  1  0: addr_out=PC, 1: addr_out=RA
- addr_out  output  ADDR_WIDTH  memory address
- pc_out  output  ADDR_WIDTH  current active PC
- ra_out  output  ADDR_WIDTH  current inactive register
- bus_out  output  WIDTH  byte chosen by read_sel
- flag_pcraflip  output  1  flip state; 0 means PC=PCRA0

Behaviour:
- Reset (synchronous, active-high), highest priority over every other input:
  - PCRA0=RESET_VECTOR, PCRA1=0, flip=0;
  - hence pc_out=RESET_VECTOR, ra_out=0, addr_out=pc_out, bus_out=RESET_VECTOR[7:0].
- Role mapping is combinational from registered state:
  - PC = flip ? PCRA1 : PCRA0
  - RA = flip ? PCRA0 : PCRA1
- inc_pcra0 and inc_pcra1 address physical registers, not roles.
  - Increment is modulo 2^ADDR_WIDTH: 16'hFFFF -> 16'h0000, no carry out.
  - Both may assert in the same cycle; each register increments independently.
- load_ra_lo/hi target the RA as decoded from the flip value *before* the edge.
  - Both asserted together: both bytes take bus_in, giving {bus_in,bus_in}.
- Load vs increment on the same physical register in the same cycle:
  - the load wins for the whole register;
  - the unloaded byte keeps its old value;
  - the increment is dropped.
- flip_req toggles flip at the edge.
  - Loads and increments in that same cycle use the pre-toggle mapping.
  - New roles are visible on the next cycle.
- Outputs are purely combinational from registers and select inputs; there is no output latency.
  - A load or increment is visible on addr_out and bus_out one cycle after the edge that captured it.
- No FSM. State is 2×ADDR_WIDTH register bits plus the flip bit.
- Assertion checks:
  - ADDR_WIDTH != 2*WIDTH: $error at elaboration.
  - read_sel is fully decoded, so it has no X path.

Decomposition:
- Shared include pcra_defs.vh holds the read_sel encodings PCRA_RD_PC_LO/PC_HI/RA_LO/RA_HI and the default RESET_VECTOR.
- One sub-module, pcra_register, is instantiated twice. It has:
  - a 16-bit register with parameterised reset value;
  - inputs inc, load_lo, load_hi and byte data;
  - load-over-increment priority implemented inside it.
- pcra_unit itself adds only the flip bit, the role mapping, and the output muxes.

Test Plan:
- Reset then inc_pcra0 held 3 cycles -> pc_out 0000,0001,0002,0003; flag_pcraflip=0; ra_out=0000.
- Set PCRA0=16'hFFFF via flip+loads+flip, then inc_pcra0 -> pc_out wraps to 16'h0000; PCRA1 unchanged.
- Jump sequence: load_ra_lo with bus_in=34, then load_ra_hi with bus_in=12, then flip_req:
  - the cycle after the flip edge, pc_out=1234 and flag_pcraflip=1;
  - ra_out = old PC (including any increments that occurred);
  - read_sel=2/3 returns the old PC bytes.
- Same cycle: flip_req=1, load_ra_lo bus_in=AA, inc_pcra1=1 with flip=0:
  - PCRA1[7:0]=AA, upper byte held, no increment;
  - next cycle pc_out=PCRA1 and flip=1.
- Reset asserted mid-sequence with inc/load/flip all active -> next cycle PCRA0=RESET_VECTOR, PCRA1=0, flip=0; all other inputs ignored.
- addr_sel=1 with RA=BEEF -> addr_out=BEEF combinationally; addr_sel=0 -> addr_out=pc_out.

Source files
------------

// File: rtl/pcra_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module : pcra_unit_pkg
// Brief  : Shared definitions for the PCRA unit: read_sel byte-select
//          encodings and the default reset vector for PCRA0.
// Rev    : 1.0  initial release
// ============================================================================
package pcra_unit_pkg;

  // Byte-select encodings for bus_out.
  typedef enum logic [1:0] {
    PCRA_RD_PC_LO = 2'd0,
    PCRA_RD_PC_HI = 2'd1,
    PCRA_RD_RA_LO = 2'd2,
    PCRA_RD_RA_HI = 2'd3
  } pcra_rd_sel_e;

  // Default value loaded into PCRA0 on reset.
  localparam logic [15:0] C_PCRA_RESET_VECTOR = 16'h0000;

endpackage : pcra_unit_pkg
`default_nettype wire

// File: rtl/pcra_unit_register.sv
`default_nettype none
// ============================================================================
// Module : pcra_register
// Brief  : One program-counter / return-address register. Byte loads take
//          priority over increment; a load of either byte cancels the
//          increment for the whole register, and the unloaded byte holds.
// Ports  : clk, reset      - clock, synchronous active-high reset
//          inc             - increment (modulo 2^ADDR_WIDTH)
//          load_lo/load_hi - write data_in into the low / high byte
//          data_in         - byte data for loads
//          value           - current register contents
// Rev    : 1.0  initial release
// ============================================================================
module pcra_register #(
  parameter int                    WIDTH      = 8,
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  inc,
  input  logic                  load_lo,
  input  logic                  load_hi,
  input  logic [WIDTH-1:0]      data_in,
  output logic [ADDR_WIDTH-1:0] value
);

  localparam logic [ADDR_WIDTH-1:0] C_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [ADDR_WIDTH-1:0] r_value;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_value <= RESET_VAL;
    end else if (load_lo || load_hi) begin
      // Load wins over increment; each byte written only if selected.
      if (load_lo) r_value[WIDTH-1:0]          <= data_in;
      if (load_hi) r_value[ADDR_WIDTH-1:WIDTH] <= data_in;
    end else if (inc) begin
      // Natural wrap FFFF -> 0000, carry discarded.
      r_value <= r_value + C_ONE;
    end
  end

  assign value = r_value;

endmodule : pcra_register
`default_nettype wire

// File: rtl/pcra_unit.sv
`default_nettype none
// ============================================================================
// Module : pcra_unit
// Brief  : Two PC/return-address registers plus the flip bit choosing which
//          one is the active PC. Jumps/calls byte-load the inactive register
//          (RA) from the data bus and then flip.
// Ports  : clk, reset            - clock, synchronous active-high reset
//          inc_pcra0/inc_pcra1   - increment physical register 0 / 1
//          flip_req              - toggle the PC/RA role mapping
//          bus_in                - byte data for RA loads
//          load_ra_lo/load_ra_hi - write bus_in into RA low / high byte
//          read_sel              - bus_out byte: PC lo, PC hi, RA lo, RA hi
//          addr_sel              - addr_out source: 0 = PC, 1 = RA
//          addr_out, pc_out, ra_out, bus_out, flag_pcraflip - outputs
// Rev    : 1.0  initial release
// ============================================================================
module pcra_unit
  import pcra_unit_pkg::*;
#(
  parameter int                    WIDTH        = 8,
  parameter int                    ADDR_WIDTH   = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = C_PCRA_RESET_VECTOR
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  inc_pcra0,
  input  logic                  inc_pcra1,
  input  logic                  flip_req,
  input  logic [WIDTH-1:0]      bus_in,
  input  logic                  load_ra_lo,
  input  logic                  load_ra_hi,
  input  logic [1:0]            read_sel,
  input  logic                  addr_sel,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic [ADDR_WIDTH-1:0] ra_out,
  output logic [WIDTH-1:0]      bus_out,
  output logic                  flag_pcraflip
);

  generate
    if (ADDR_WIDTH != 2 * WIDTH) begin : g_width_check
      $error("pcra_unit: ADDR_WIDTH must equal 2*WIDTH");
    end
  endgenerate

  logic                  r_flip;
  logic [ADDR_WIDTH-1:0] w_pcra0;
  logic [ADDR_WIDTH-1:0] w_pcra1;
  logic                  w_ld0_lo, w_ld0_hi, w_ld1_lo, w_ld1_hi;

  // RA is PCRA1 while flip=0, PCRA0 while flip=1; loads steer by the
  // pre-edge flip value so a flip in the same cycle does not redirect them.
  assign w_ld0_lo =  r_flip & load_ra_lo;
  assign w_ld0_hi =  r_flip & load_ra_hi;
  assign w_ld1_lo = ~r_flip & load_ra_lo;
  assign w_ld1_hi = ~r_flip & load_ra_hi;

  pcra_register #(
    .WIDTH      (WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .RESET_VAL  (RESET_VECTOR)
  ) u_pcra0 (
    .clk     (clk),
    .reset   (reset),
    .inc     (inc_pcra0),
    .load_lo (w_ld0_lo),
    .load_hi (w_ld0_hi),
    .data_in (bus_in),
    .value   (w_pcra0)
  );

  pcra_register #(
    .WIDTH      (WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .RESET_VAL  ('0)
  ) u_pcra1 (
    .clk     (clk),
    .reset   (reset),
    .inc     (inc_pcra1),
    .load_lo (w_ld1_lo),
    .load_hi (w_ld1_hi),
    .data_in (bus_in),
    .value   (w_pcra1)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_flip <= 1'b0;
    end else if (flip_req) begin
      r_flip <= ~r_flip;
    end
  end

  logic [ADDR_WIDTH-1:0] w_pc;
  logic [ADDR_WIDTH-1:0] w_ra;
  logic [WIDTH-1:0]      w_bus;

  assign w_pc = r_flip ? w_pcra1 : w_pcra0;
  assign w_ra = r_flip ? w_pcra0 : w_pcra1;

  always_comb begin
    w_bus = w_pc[WIDTH-1:0];
    case (read_sel)
      PCRA_RD_PC_LO: w_bus = w_pc[WIDTH-1:0];
      PCRA_RD_PC_HI: w_bus = w_pc[ADDR_WIDTH-1:WIDTH];
      PCRA_RD_RA_LO: w_bus = w_ra[WIDTH-1:0];
      PCRA_RD_RA_HI: w_bus = w_ra[ADDR_WIDTH-1:WIDTH];
      default:       w_bus = w_pc[WIDTH-1:0];
    endcase
  end

  assign pc_out        = w_pc;
  assign ra_out        = w_ra;
  assign addr_out      = addr_sel ? w_ra : w_pc;
  assign bus_out       = w_bus;
  assign flag_pcraflip = r_flip;

endmodule : pcra_unit
`default_nettype wire
